balance_ledger: RTL and testbench

Credit/debit engine owning the player balance in packed 4-digit BCD. It sits directly upstream of the balance display path: it consumes debounced lever pulses (bets) and win payouts from the reel engine, and its `bal_bcd` output feeds the seven-segment mux. Arithmetic is digit-serial, one BCD digit per clock, so the block needs no binary-to-BCD converter. `bal_bcd` changes only at commit, so the display never shows a partial result.

---
 rtl/balance_ledger_if.sv | 25 ++
 rtl/balance_ledger.sv | 136 +++++++++++++
 tb/tb_balance_ledger.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/balance_ledger_if.sv
// Credit/debit handshake bundle between the reel engine,
// the lever debouncer and the balance ledger.
interface balance_ledger_if;
    logic        bet_req;
    logic        win_valid;
    logic [15:0] win_bcd;
    logic        win_ready;
    logic        bet_ok;
    logic        bet_denied;
    logic        sat;
    logic        busy;
    logic [15:0] bal_bcd;

    modport master (
        output bet_req, win_valid, win_bcd,
        input  win_ready, bet_ok, bet_denied,
        input  sat, busy, bal_bcd
    );

    modport slave (
        input  bet_req, win_valid, win_bcd,
        output win_ready, bet_ok, bet_denied,
        output sat, busy, bal_bcd
    );
endinterface

// File: rtl/balance_ledger.sv
// Digit-serial packed-BCD balance ledger: credits payouts,
// debits bets, commits whole results only.
module balance_ledger #(
    parameter logic [15:0] INIT_BAL = 16'h0100,
    parameter logic [15:0] BET_BCD  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    balance_ledger_if.slave  lb
);
    typedef enum logic [1:0] {
        IDLE, CMP, DIG, COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc, win_q, bal_q;
    logic [1:0]  d;
    logic        c, sub, bet_pend;
    logic        rdy_q, busy_q, ok_q, den_q, sat_q;

    logic        take_win, take_bet;
    logic [15:0] opnd;
    logic [3:0]  a_dig, b_raw, b_dig, r_dig;
    logic [4:0]  bc, sum;
    logic        c_nxt;

    always_comb begin
        take_win = (state_q == IDLE) && lb.win_valid && rdy_q;
        take_bet = (state_q == IDLE) && !take_win && bet_pend;
        state_d  = state_q;
        unique case (state_q)
            IDLE: begin
                if (take_win)      state_d = DIG;
                else if (take_bet) state_d = CMP;
            end
            CMP:    state_d = (bal_q >= BET_BCD) ? DIG : IDLE;
            DIG:    if (d == 2'd3) state_d = COMMIT;
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One BCD digit per clock; malformed digits saturate to 9
    always_comb begin
        opnd  = sub ? BET_BCD : win_q;
        a_dig = acc[{d, 2'b00} +: 4];
        b_raw = opnd[{d, 2'b00} +: 4];
        b_dig = (b_raw > 4'd9) ? 4'd9 : b_raw;
        bc    = {1'b0, b_dig} + {4'b0, c};
        sum   = '0;
        c_nxt = 1'b0;
        if (!sub) begin
            sum = {1'b0, a_dig} + bc;
            if (sum > 5'd9) begin
                sum   = sum - 5'd10;
                c_nxt = 1'b1;
            end
        end else if ({1'b0, a_dig} >= bc) begin
            sum = {1'b0, a_dig} - bc;
        end else begin
            sum   = {1'b0, a_dig} + 5'd10 - bc;
            c_nxt = 1'b1;
        end
        r_dig = sum[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc      <= '0;
            win_q    <= '0;
            d        <= '0;
            c        <= 1'b0;
            sub      <= 1'b0;
            bet_pend <= 1'b0;
            bal_q    <= INIT_BAL;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
            den_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= (state_d == IDLE);
            busy_q   <= (state_d != IDLE);
            ok_q     <= 1'b0;
            den_q    <= 1'b0;
            sat_q    <= 1'b0;
            bet_pend <= take_bet ? 1'b0
                      : (bet_pend | lb.bet_req);
            unique case (state_q)
                IDLE: begin
                    if (take_win) begin
                        win_q <= lb.win_bcd;
                        acc   <= bal_q;
                        sub   <= 1'b0;
                        d     <= '0;
                        c     <= 1'b0;
                    end
                end
                CMP: begin
                    if (state_d == DIG) begin
                        sub <= 1'b1;
                        acc <= bal_q;
                        d   <= '0;
                        c   <= 1'b0;
                    end else begin
                        den_q <= 1'b1;
                    end
                end
                DIG: begin
                    acc[{d, 2'b00} +: 4] <= r_dig;
                    c <= c_nxt;
                    d <= d + 2'd1;
                end
                COMMIT: begin
                    if (!sub && c) begin
                        bal_q <= 16'h9999;
                        sat_q <= 1'b1;
                    end else begin
                        bal_q <= acc;
                    end
                    ok_q <= sub;
                end
                default: ;
            endcase
        end
    end

    assign lb.win_ready  = rdy_q;
    assign lb.busy       = busy_q;
    assign lb.bet_ok     = ok_q;
    assign lb.bet_denied = den_q;
    assign lb.sat        = sat_q;
    assign lb.bal_bcd    = bal_q;
endmodule

// File: tb/tb_balance_ledger.sv
// Directed bench for balance_ledger: credit, debit, deny,
// saturation, digit clamp, reset abort and win/bet overlap.
module tb_balance_ledger;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    balance_ledger_if lb ();

    balance_ledger #(
        .INIT_BAL (16'h0100),
        .BET_BCD  (16'h0001)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lb    (lb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step after the accepting edge E0
    task automatic start_win(input logic [15:0] amt);
        lb.win_valid = 1'b1;
        lb.win_bcd   = amt;
        tick();
        lb.win_valid = 1'b0;
        lb.win_bcd   = 16'h0;
    endtask

    // Leaves the bench one step after the request edge
    task automatic req_bet;
        lb.bet_req = 1'b1;
        tick();
        lb.bet_req = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++;
        if (lb.bal_bcd !== 16'h0100)
            $display("FAIL rst_bal got %h want 0100", lb.bal_bcd);
        else passes++;
        checks++;
        if ({lb.win_ready, lb.busy} !== 2'b00)
            $display("FAIL rst_rdy_busy got %b want 00",
                     {lb.win_ready, lb.busy});
        else passes++;
        checks++;
        if ({lb.bet_ok, lb.bet_denied, lb.sat} !== 3'b000)
            $display("FAIL rst_pulses got %b want 000",
                     {lb.bet_ok, lb.bet_denied, lb.sat});
        else passes++;
        rst_n = 1'b1;
        checks++;
        if (lb.win_ready !== 1'b0)
            $display("FAIL rel_rdy got %b want 0", lb.win_ready);
        else passes++;
        tick();
        checks++;
        if (lb.win_ready !== 1'b1)
            $display("FAIL rel_rdy1 got %b want 1", lb.win_ready);
        else passes++;
    endtask

    task automatic test_credit;
        int low;
        low = 0;
        start_win(16'h0250);
        checks++;
        if (lb.busy !== 1'b1)
            $display("FAIL cr_busy got %b want 1", lb.busy);
        else passes++;
        for (int i = 0; i < 12; i++) begin
            if (lb.win_ready) break;
            if (lb.bal_bcd !== 16'h0100) break;
            low++;
            tick();
        end
        checks++;
        if (low !== 5)
            $display("FAIL cr_rdy_low got %0d want 5", low);
        else passes++;
        checks++;
        if (lb.bal_bcd !== 16'h0350)
            $display("FAIL cr_bal got %h want 0350", lb.bal_bcd);
        else passes++;
        checks++;
        if ({lb.sat, lb.busy} !== 2'b00)
            $display("FAIL cr_sat_busy got %b want 00",
                     {lb.sat, lb.busy});
        else passes++;
    endtask

    task automatic test_reset_mid;
        start_win(16'h0005);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (lb.bal_bcd !== 16'h0100)
            $display("FAIL mid_bal got %h want 0100", lb.bal_bcd);
        else passes++;
        checks++;
        if ({lb.win_ready, lb.busy} !== 2'b00)
            $display("FAIL mid_rdy_busy got %b want 00",
                     {lb.win_ready, lb.busy});
        else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (lb.win_ready !== 1'b1)
            $display("FAIL mid_rdy got %b want 1", lb.win_ready);
        else passes++;
        repeat (7) tick();
        checks++;
        if ({lb.bal_bcd, lb.busy} !== {16'h0100, 1'b0})
            $display("FAIL mid_discard got %h/%b want 0100/0",
                     lb.bal_bcd, lb.busy);
        else passes++;
    endtask

    task automatic test_borrow;
        start_win(16'h0900);
        repeat (5) tick();
        checks++;
        if (lb.bal_bcd !== 16'h1000)
            $display("FAIL bw_pre got %h want 1000", lb.bal_bcd);
        else passes++;
        req_bet();
        repeat (6) tick();
        checks++;
        if ({lb.bal_bcd, lb.bet_ok} !== {16'h1000, 1'b0})
            $display("FAIL bw_e5 got %h/%b want 1000/0",
                     lb.bal_bcd, lb.bet_ok);
        else passes++;
        tick();
        checks++;
        if ({lb.bal_bcd, lb.bet_ok} !== {16'h0999, 1'b1})
            $display("FAIL bw_e6 got %h/%b want 0999/1",
                     lb.bal_bcd, lb.bet_ok);
        else passes++;
        tick();
        checks++;
        if (lb.bet_ok !== 1'b0)
            $display("FAIL bw_pulse got %b want 0", lb.bet_ok);
        else passes++;
    endtask

    task automatic test_denied;
        int oks;
        oks = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            req_bet();
            repeat (7) tick();
            if (lb.bet_ok) oks++;
        end
        checks++;
        if ({lb.bal_bcd, oks} !== {16'h0000, 32'd100})
            $display("FAIL drain got %h/%0d want 0000/100",
                     lb.bal_bcd, oks);
        else passes++;
        req_bet();
        tick();
        checks++;
        if ({lb.bet_denied, lb.busy} !== 2'b01)
            $display("FAIL den_e0 got %b want 01",
                     {lb.bet_denied, lb.busy});
        else passes++;
        tick();
        checks++;
        if ({lb.bet_denied, lb.busy, lb.bet_ok} !== 3'b100)
            $display("FAIL den_e1 got %b want 100",
                     {lb.bet_denied, lb.busy, lb.bet_ok});
        else passes++;
        oks = 0;
        repeat (8) begin
            tick();
            if (lb.bet_ok) oks++;
        end
        checks++;
        if ({lb.bal_bcd, oks} !== {16'h0000, 32'd0})
            $display("FAIL den_after got %h/%0d want 0000/0",
                     lb.bal_bcd, oks);
        else passes++;
    endtask

    task automatic test_clamp_sat;
        start_win(16'h00F0);
        repeat (5) tick();
        checks++;
        if (lb.bal_bcd !== 16'h0090)
            $display("FAIL clamp got %h want 0090", lb.bal_bcd);
        else passes++;
        start_win(16'h9900);
        repeat (5) tick();
        checks++;
        if ({lb.bal_bcd, lb.sat} !== {16'h9990, 1'b0})
            $display("FAIL pre_sat got %h/%b want 9990/0",
                     lb.bal_bcd, lb.sat);
        else passes++;
        start_win(16'h0025);
        repeat (5) tick();
        checks++;
        if ({lb.bal_bcd, lb.sat} !== {16'h9999, 1'b1})
            $display("FAIL sat got %h/%b want 9999/1",
                     lb.bal_bcd, lb.sat);
        else passes++;
        tick();
        checks++;
        if (lb.sat !== 1'b0)
            $display("FAIL sat_pulse got %b want 0", lb.sat);
        else passes++;
    endtask

    task automatic test_simultaneous;
        do_reset();
        lb.bet_req = 1'b1;
        start_win(16'h0005);
        lb.bet_req = 1'b0;
        tick();
        req_bet();
        repeat (3) tick();
        checks++;
        if ({lb.bal_bcd, lb.bet_ok} !== {16'h0105, 1'b0})
            $display("FAIL sim_cr got %h/%b want 0105/0",
                     lb.bal_bcd, lb.bet_ok);
        else passes++;
        repeat (6) tick();
        checks++;
        if ({lb.bal_bcd, lb.bet_ok} !== {16'h0105, 1'b0})
            $display("FAIL sim_e11 got %h/%b want 0105/0",
                     lb.bal_bcd, lb.bet_ok);
        else passes++;
        tick();
        checks++;
        if ({lb.bal_bcd, lb.bet_ok} !== {16'h0104, 1'b1})
            $display("FAIL sim_db got %h/%b want 0104/1",
                     lb.bal_bcd, lb.bet_ok);
        else passes++;
        repeat (12) tick();
        checks++;
        if ({lb.bal_bcd, lb.busy} !== {16'h0104, 1'b0})
            $display("FAIL sim_drop got %h/%b want 0104/0",
                     lb.bal_bcd, lb.busy);
        else passes++;
    endtask

    initial begin
        lb.bet_req   = 1'b0;
        lb.win_valid = 1'b0;
        lb.win_bcd   = 16'h0;
        test_reset();
        test_credit();
        test_reset_mid();
        test_borrow();
        test_denied();
        test_clamp_sat();
        test_simultaneous();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
